// File: rtl/counter_event_logger.sv
// counter_event_logger: watches a free-running counter, classifies each valid
// sample as START / WRAP / JUMP, and queues the events with a cycle timestamp
// in a small FIFO drained by a valid/ready reader.
module counter_event_logger #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         cnt_in,
  input  logic                     cnt_valid,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_code,
  output logic [WIDTH-1:0]         ev_value,
  output logic [TS_WIDTH-1:0]      ev_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 + WIDTH + TS_WIDTH;

  typedef enum logic [1:0] {
    EV_START = 2'd0,
    EV_WRAP  = 2'd1,
    EV_JUMP  = 2'd2
  } ev_code_t;

  // Observation state
  logic [WIDTH-1:0]    r_prev;
  logic                r_have_prev;
  logic [TS_WIDTH-1:0] r_ts;

  // FIFO state; r_head mirrors the entry at r_rd_ptr so outputs are registered
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_wr_ptr;
  logic [LW-1:0]       r_level;
  logic [7:0]          r_drop_cnt;
  logic                r_ev_valid;
  logic [EW-1:0]       r_head;

  logic [WIDTH-1:0]    w_prev_inc;
  logic                w_push;
  ev_code_t            w_code;
  logic [EW-1:0]       w_entry;
  logic                w_pop;
  logic                w_full;
  logic                w_accept;
  logic                w_drop;
  logic [AW-1:0]       w_rd_ptr_inc;
  logic [LW-1:0]       w_level_next;
  logic [EW-1:0]       w_head_next;

  assign w_prev_inc   = r_prev + WIDTH'(1);
  assign w_entry      = {w_code, cnt_in, r_ts};
  assign w_pop        = r_ev_valid & ev_ready;
  assign w_full       = (r_level == LW'(DEPTH));
  assign w_accept     = w_push & (~w_full | w_pop);
  assign w_drop       = w_push & ~w_accept;
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  // Classify the current sample; an in-sequence step other than the wrap is silent
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_push = 1'b0;
    w_code = EV_JUMP;
    if (cnt_valid) begin
      if (!r_have_prev) begin
        w_push = 1'b1;
        w_code = EV_START;
      end else if (cnt_in == w_prev_inc) begin
        if (cnt_in == '0) begin
          w_push = 1'b1;
          w_code = EV_WRAP;
        end
      end else begin
        w_push = 1'b1;
        w_code = EV_JUMP;
      end
    end
  end

  // Next occupancy and next head entry after this cycle's push/pop
  always_comb begin
    w_level_next = r_level;
    w_head_next  = r_head;
    case ({w_accept, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
    // The pushed entry becomes head when the queue is (or is about to be) empty
    if (w_accept && (w_pop ? (r_level == LW'(1)) : (r_level == '0))) begin
      w_head_next = w_entry;
    end else if (w_pop) begin
      w_head_next = r_mem[w_rd_ptr_inc];
    end
  end

  // Control state, timestamp and registered outputs
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_ts        <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_drop_cnt  <= '0;
      r_ev_valid  <= 1'b0;
      r_head      <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (cnt_valid) begin
        r_prev      <= cnt_in;
        r_have_prev <= 1'b1;
      end else begin
        r_have_prev <= 1'b0;
      end
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= w_rd_ptr_inc;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      r_level    <= w_level_next;
      r_ev_valid <= (w_level_next != '0);
      r_head     <= w_head_next;
    end
  end

  // Event storage written on every accepted push
  // NOTE: the storage array is deliberately not reset; level/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_entry;
  end

  assign ev_valid = r_ev_valid;
  assign ev_code  = r_head[EW-1 -: 2];
  assign ev_value = r_head[TS_WIDTH +: WIDTH];
  assign ev_time  = r_head[TS_WIDTH-1:0];
  assign level    = r_level;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed testbench for counter_event_logger: one task per scenario, inline checks.
module tb_counter_event_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cnt_in;
  logic        cnt_valid;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_code;
  logic [7:0]  ev_value;
  logic [15:0] ev_time;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [1:0]  code;
    logic [7:0]  value;
    logic [15:0] ts;
  } ev_t;

  ev_t seen[$];

  counter_event_logger #(.WIDTH(8), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_value(ev_value), .ev_time(ev_time), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record the head if valid (used while ev_ready=1, so each valid cycle is a new entry)
  task automatic step_collect();
    step();
    if (ev_valid) seen.push_back('{code: ev_code, value: ev_value, ts: ev_time});
  endtask

  task automatic test_reset();
    reset = 1'b1; cnt_valid = 1'b0; cnt_in = 8'd0; ev_ready = 1'b0;
    step(); step();
    n_total++;
    if ({ev_valid, level, drop_cnt} !== {1'b0, 4'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_status: got valid=%0b level=%0d drop=%0d want 0/0/0", ev_valid, level, drop_cnt);
    end
    n_total++;
    if ({ev_code, ev_value, ev_time} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_head: got code=%0d value=%0d time=%0d want 0/0/0", ev_code, ev_value, ev_time);
    end
  endtask

  task automatic test_basic_count();
    ev_t exp0, exp1;
    reset = 1'b0; cnt_valid = 1'b0; cnt_in = 8'd0; ev_ready = 1'b1;
    step(); step();
    seen.delete();
    cnt_valid = 1'b1;
    for (int k = 0; k < 258; k++) begin
      cnt_in = 8'(k);
      step_collect();
    end
    cnt_valid = 1'b0;
    step_collect(); step_collect();
    exp0 = '{code: 2'd0, value: 8'd0, ts: 16'd2};
    exp1 = '{code: 2'd1, value: 8'd0, ts: 16'd258};
    n_total++;
    if (seen.size() !== 2) begin
      n_bad++;
      $display("FAIL basic_count_events: got %0d events want 2", seen.size());
    end
    if (seen.size() >= 1) begin
      n_total++;
      if (seen[0] !== exp0) begin
        n_bad++;
        $display("FAIL basic_start: got code=%0d value=%0d ts=%0d want 0/0/2", seen[0].code, seen[0].value, seen[0].ts);
      end
    end
    if (seen.size() >= 2) begin
      n_total++;
      if (seen[1] !== exp1) begin
        n_bad++;
        $display("FAIL basic_wrap: got code=%0d value=%0d ts=%0d want 1/0/258", seen[1].code, seen[1].value, seen[1].ts);
      end
    end
    n_total++;
    if (drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL basic_drop: got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_jump_hold();
    logic [7:0] stim [6] = '{8'd3, 8'd4, 8'd5, 8'd9, 8'd9, 8'd10};
    logic [9:0] exp  [3] = '{{2'd0, 8'd3}, {2'd2, 8'd9}, {2'd2, 8'd9}};
    seen.delete();
    ev_ready = 1'b1; cnt_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cnt_in = stim[i];
      step_collect();
    end
    cnt_valid = 1'b0;
    step_collect(); step_collect();
    n_total++;
    if (seen.size() !== 3) begin
      n_bad++;
      $display("FAIL jump_event_count: got %0d events want 3", seen.size());
    end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_total++;
      if ({seen[i].code, seen[i].value} !== exp[i]) begin
        n_bad++;
        $display("FAIL jump_event_%0d: got code=%0d value=%0d want code=%0d value=%0d",
                 i, seen[i].code, seen[i].value, exp[i][9:8], exp[i][7:0]);
      end
    end
    // Consecutive JUMPs sampled on consecutive cycles differ by one timestamp
    if (seen.size() >= 3) begin
      n_total++;
      if (seen[2].ts !== seen[1].ts + 16'd1) begin
        n_bad++;
        $display("FAIL jump_ts_step: got %0d want %0d", seen[2].ts, seen[1].ts + 16'd1);
      end
    end
  endtask

  task automatic test_overflow();
    ev_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cnt_valid = 1'b0; step();
      cnt_valid = 1'b1; cnt_in = 8'(k); step();
    end
    cnt_valid = 1'b0;
    step();
    n_total++;
    if ({level, drop_cnt} !== {4'd8, 8'd2}) begin
      n_bad++;
      $display("FAIL overflow_level_drop: got level=%0d drop=%0d want 8/2", level, drop_cnt);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if ({ev_valid, ev_code, ev_value} !== {1'b1, 2'd0, 8'(i)}) begin
        n_bad++;
        $display("FAIL overflow_drain_%0d: got valid=%0b code=%0d value=%0d want 1/0/%0d", i, ev_valid, ev_code, ev_value, i);
      end
      step();
    end
    n_total++;
    if ({ev_valid, level} !== {1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL overflow_empty: got valid=%0b level=%0d want 0/0", ev_valid, level);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [9:0] exp [8];
    ev_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cnt_valid = 1'b0; step();
      cnt_valid = 1'b1; cnt_in = 8'h40 + 8'(k); step();
    end
    // FIFO now full; cnt_valid stays high so a jump to 0x60 is a JUMP
    cnt_in = 8'h60; ev_ready = 1'b1;
    step();
    cnt_valid = 1'b0;
    n_total++;
    if ({level, drop_cnt} !== {4'd8, 8'd2}) begin
      n_bad++;
      $display("FAIL fullpop_level_drop: got level=%0d drop=%0d want 8/2", level, drop_cnt);
    end
    for (int i = 0; i < 7; i++) exp[i] = {2'd0, 8'h41 + 8'(i)};
    exp[7] = {2'd2, 8'h60};
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if ({ev_valid, ev_code, ev_value} !== {1'b1, exp[i]}) begin
        n_bad++;
        $display("FAIL fullpop_drain_%0d: got valid=%0b code=%0d value=%0h want 1/%0d/%0h",
                 i, ev_valid, ev_code, ev_value, exp[i][9:8], exp[i][7:0]);
      end
      step();
    end
    n_total++;
    if (ev_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fullpop_empty: got valid=%0b want 0", ev_valid);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; cnt_valid = 1'b0; ev_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      cnt_valid = 1'b0; step();
      cnt_valid = 1'b1; cnt_in = 8'(k); step();
    end
    cnt_valid = 1'b0; ev_ready = 1'b1;
    step(); step(); step();
    ev_ready = 1'b0;
    n_total++;
    if ({level, drop_cnt} !== {4'd5, 8'd3}) begin
      n_bad++;
      $display("FAIL midreset_setup: got level=%0d drop=%0d want 5/3", level, drop_cnt);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; cnt_valid = 1'b1; cnt_in = 8'h33;
    n_total++;
    if ({ev_valid, level, drop_cnt} !== {1'b0, 4'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL midreset_clear: got valid=%0b level=%0d drop=%0d want 0/0/0", ev_valid, level, drop_cnt);
    end
    step();
    cnt_valid = 1'b0;
    n_total++;
    if ({ev_valid, ev_code, ev_value, ev_time} !== {1'b1, 2'd0, 8'h33, 16'd0}) begin
      n_bad++;
      $display("FAIL midreset_start: got valid=%0b code=%0d value=%0h time=%0d want 1/0/33/0",
               ev_valid, ev_code, ev_value, ev_time);
    end
  endtask

  task automatic test_drop_saturation();
    // One entry already queued; a held value yields an event every cycle
    ev_ready = 1'b0; cnt_valid = 1'b1; cnt_in = 8'd5;
    for (int i = 0; i < 107; i++) step();
    n_total++;
    if ({level, drop_cnt} !== {4'd8, 8'd100}) begin
      n_bad++;
      $display("FAIL sat_partial: got level=%0d drop=%0d want 8/100", level, drop_cnt);
    end
    for (int i = 0; i < 200; i++) step();
    cnt_valid = 1'b0;
    step();
    n_total++;
    if ({level, drop_cnt} !== {4'd8, 8'd255}) begin
      n_bad++;
      $display("FAIL sat_hold: got level=%0d drop=%0d want 8/255", level, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_jump_hold();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_drop_saturation();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
